cam_frame_sequencer: RTL and testbench

CAM_FRAME_SEQUENCER -- requirements
Module: cam_frame_sequencer

---
 rtl/cam_frame_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_cam_frame_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_frame_sequencer.sv
// cam_frame_sequencer: steers a stream of assembled camera pixels into a frame
// buffer. Supports continuous, single-shot, burst and freeze capture modes and
// optional ping-pong buffering.
// Optional feature: define FRAME_GRAY_EN to register a Gray-coded copy of the
// frame counter on frame_gray; otherwise frame_gray is tied to zero.
module cam_frame_sequencer #(
    parameter int C_IMG_COLS    = 80,
    parameter int C_IMG_ROWS    = 60,
    parameter int C_NB_IMG_PXLS = 13,
    parameter int C_NB_BUF      = 16,
    parameter int C_NB_FCNT     = 8,
    parameter int C_DBL_BUF     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vsync,
    input  logic                     pxl_valid,
    input  logic [C_NB_BUF-1:0]      pxl_data,
    input  logic [1:0]               mode,
    input  logic [7:0]               burst_len,
    input  logic                     start,
    output logic                     wr_en,
    output logic [C_NB_IMG_PXLS-1:0] wr_addr,
    output logic [C_NB_BUF-1:0]      wr_data,
    output logic                     wr_buf,
    output logic                     rd_buf,
    output logic [C_NB_FCNT-1:0]     frame_cnt,
    output logic [C_NB_FCNT-1:0]     frame_gray,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam int C_IMG_PXLS = C_IMG_COLS * C_IMG_ROWS;
    localparam logic [C_NB_IMG_PXLS-1:0] PXL_LIMIT = C_NB_IMG_PXLS'(C_IMG_PXLS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_VS = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_STOP    = 2'd3;

    localparam logic [1:0] MODE_CONT   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    // A burst length of zero still captures one frame.
    function automatic logic [7:0] burst_frames(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

    logic [1:0]               state_q, state_d;
    logic                     vs_q;
    logic [C_NB_IMG_PXLS-1:0] addr_q, addr_d;
    logic [7:0]               rem_q, rem_d;
    logic                     wr_en_q, wr_en_d;
    logic [C_NB_IMG_PXLS-1:0] wr_addr_q, wr_addr_d;
    logic [C_NB_BUF-1:0]      wr_data_q, wr_data_d;
    logic                     wr_buf_q, wr_buf_d;
    logic                     rd_buf_q, rd_buf_d;
    logic [C_NB_FCNT-1:0]     cnt_q, cnt_d;
    logic                     done_q, done_d;
    logic                     ovf_q, ovf_d;
    logic                     vs_rise;

    assign vs_rise = vsync & ~vs_q;

    // Next-state and datapath decisions for the capture sequencer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_buf_d  = wr_buf_q;
        rd_buf_d  = rd_buf_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (mode == MODE_CONT) begin
                    state_d = ST_WAIT_VS;
                end else if (start && (mode == MODE_SINGLE)) begin
                    state_d = ST_WAIT_VS;
                    rem_d   = 8'd1;
                end else if (start && (mode == MODE_BURST)) begin
                    state_d = ST_WAIT_VS;
                    rem_d   = burst_frames(burst_len);
                end
            end
            ST_WAIT_VS: begin
                if (vs_rise) begin
                    state_d = ST_CAPTURE;
                    addr_d  = '0;
                end
            end
            ST_CAPTURE: begin
                if (vs_rise) begin
                    // Frame boundary: any pixel on this cycle is dropped and the
                    // same edge opens the next frame unless capture stops here.
                    cnt_d    = cnt_q + C_NB_FCNT'(1);
                    done_d   = 1'b1;
                    rd_buf_d = wr_buf_q;
                    if (C_DBL_BUF != 0) begin
                        wr_buf_d = ~wr_buf_q;
                    end
                    addr_d = '0;
                    if ((mode != MODE_CONT) && (rem_q != 8'd0)) begin
                        rem_d = rem_q - 8'd1;
                    end
                    if ((mode == MODE_FREEZE) || ((mode != MODE_CONT) && (rem_q <= 8'd1))) begin
                        state_d = ST_STOP;
                    end
                end else if (pxl_valid) begin
                    if (addr_q < PXL_LIMIT) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = pxl_data;
                        addr_d    = addr_q + C_NB_IMG_PXLS'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered write port, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vs_q      <= 1'b0;
            addr_q    <= '0;
            rem_q     <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_buf_q  <= 1'b0;
            rd_buf_q  <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs_q      <= vsync;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_buf_q  <= wr_buf_d;
            rd_buf_q  <= rd_buf_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef FRAME_GRAY_EN
    function automatic logic [C_NB_FCNT-1:0] to_gray(input logic [C_NB_FCNT-1:0] v);
        return v ^ (v >> 1);
    endfunction

    logic [C_NB_FCNT-1:0] gray_q;

    // Gray copy of the frame counter, updated on the same edge as the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q <= '0;
        end else begin
            gray_q <= to_gray(cnt_d);
        end
    end

    assign frame_gray = gray_q;
`else
    assign frame_gray = '0;
`endif

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_buf    = wr_buf_q;
    assign rd_buf    = rd_buf_q;
    assign frame_cnt = cnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_cam_frame_sequencer.sv
// tb_cam_frame_sequencer: directed scenarios plus a randomized run, checked
// every cycle against a frame-level behavioural model kept in the bench.
`timescale 1ns/1ps
module tb_cam_frame_sequencer;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int PXLS  = COLS * ROWS;
    localparam int NB_A  = 13;
    localparam int NB_B  = 16;
    localparam int NB_F  = 8;
    localparam int DBL   = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            vsync;
    logic            pxl_valid;
    logic [NB_B-1:0] pxl_data;
    logic [1:0]      mode;
    logic [7:0]      burst_len;
    logic            start;
    logic            wr_en;
    logic [NB_A-1:0] wr_addr;
    logic [NB_B-1:0] wr_data;
    logic            wr_buf;
    logic            rd_buf;
    logic [NB_F-1:0] frame_cnt;
    logic [NB_F-1:0] frame_gray;
    logic            busy;
    logic            done;
    logic            overflow;

    always #5 clk = ~clk;

    cam_frame_sequencer #(
        .C_IMG_COLS(COLS), .C_IMG_ROWS(ROWS), .C_NB_IMG_PXLS(NB_A),
        .C_NB_BUF(NB_B), .C_NB_FCNT(NB_F), .C_DBL_BUF(DBL)
    ) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .pxl_valid(pxl_valid),
        .pxl_data(pxl_data), .mode(mode), .burst_len(burst_len), .start(start),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_buf(wr_buf),
        .rd_buf(rd_buf), .frame_cnt(frame_cnt), .frame_gray(frame_gray),
        .busy(busy), .done(done), .overflow(overflow)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_live = 0;
    bit m_vs, armed, capturing, stopping;
    int m_addr, m_rem;
    bit e_wr_en, e_wr_buf, e_rd_buf, e_done, e_ovf;
    int e_wr_addr, e_wr_data, e_cnt;
    int m_nwr = 0;
    int m_ndone = 0;

    task automatic model_step();
        bit rise;
        rise    = vsync && !m_vs;
        e_wr_en = 0;
        e_done  = 0;
        if (rst) begin
            m_live = 1; m_vs = 0; armed = 0; capturing = 0; stopping = 0;
            m_addr = 0; m_rem = 0; e_wr_addr = 0; e_wr_data = 0;
            e_wr_buf = 0; e_rd_buf = 0; e_cnt = 0; e_ovf = 0;
        end else if (m_live) begin
            if (stopping) begin
                stopping = 0;
            end else if (capturing) begin
                if (rise) begin
                    e_cnt = (e_cnt + 1) % (1 << NB_F);
                    e_done = 1;
                    m_ndone++;
                    e_rd_buf = e_wr_buf;
                    if (DBL == 1) e_wr_buf = !e_wr_buf;
                    if (mode != 2'b00 && m_rem > 0) m_rem--;
                    if (mode == 2'b11 || (mode != 2'b00 && m_rem == 0)) begin
                        capturing = 0;
                        stopping  = 1;
                    end
                    m_addr = 0;
                end else if (pxl_valid) begin
                    if (m_addr < PXLS) begin
                        e_wr_en = 1; e_wr_addr = m_addr; e_wr_data = int'(pxl_data);
                        m_addr++; m_nwr++;
                    end else begin
                        e_ovf = 1;
                    end
                end
            end else if (armed) begin
                if (rise) begin
                    armed = 0; capturing = 1; m_addr = 0;
                end
            end else begin
                if (mode == 2'b00) armed = 1;
                else if (start && mode == 2'b01) begin armed = 1; m_rem = 1; end
                else if (start && mode == 2'b10) begin
                    armed = 1;
                    m_rem = (burst_len == 0) ? 1 : int'(burst_len);
                end
            end
            m_vs = vsync;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            int g;
`ifdef FRAME_GRAY_EN
            g = e_cnt ^ (e_cnt >> 1);
`else
            g = 0;
`endif
            chk("wr_en",      32'(wr_en),      32'(e_wr_en));
            chk("wr_addr",    32'(wr_addr),    e_wr_addr);
            chk("wr_data",    32'(wr_data),    e_wr_data);
            chk("wr_buf",     32'(wr_buf),     32'(e_wr_buf));
            chk("rd_buf",     32'(rd_buf),     32'(e_rd_buf));
            chk("frame_cnt",  32'(frame_cnt),  e_cnt);
            chk("frame_gray", 32'(frame_gray), g);
            chk("busy",       32'(busy),       32'(armed || capturing || stopping));
            chk("done",       32'(done),       32'(e_done));
            chk("overflow",   32'(overflow),   32'(e_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit r, input bit v, input bit pv, input bit st);
        @(negedge clk);
        rst = r; vsync = v; pxl_valid = pv; start = st;
        pxl_data = NB_B'($urandom);
    endtask

    task automatic vs_edge();
        drive(0, 1, 1'($urandom_range(0, 1)), 0);
        drive(0, 0, 0, 0);
    endtask

    task automatic pixels(input int n, input int pct);
        int sent = 0;
        while (sent < n) begin
            bit pv;
            pv = ($urandom_range(0, 99) < pct);
            drive(0, 0, pv, 0);
            if (pv) sent++;
        end
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("rst_wr_en",    32'(wr_en), 0);
        chk("rst_wr_addr",  32'(wr_addr), 0);
        chk("rst_wr_data",  32'(wr_data), 0);
        chk("rst_bufs",     32'({wr_buf, rd_buf}), 0);
        chk("rst_cnt",      32'(frame_cnt), 0);
        chk("rst_gray",     32'(frame_gray), 0);
        chk("rst_flags",    32'({busy, done, overflow}), 0);
        drive(0, 0, 0, 0);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int w0, d0;
        rst = 1; vsync = 0; pxl_valid = 0; start = 0; pxl_data = '0;
        mode = 2'b11; burst_len = 8'd0;
        do_reset();

        // Continuous capture of two full frames.
        mode = 2'b00;
        do_reset();
        w0 = m_nwr; d0 = m_ndone;
        drive(0, 0, 0, 0);
        vs_edge();
        pixels(PXLS, 90);
        vs_edge();
        chk("s1_f1_writes", m_nwr - w0, 4800);
        chk("s1_f1_cnt", 32'(frame_cnt), 1);
        chk("s1_f1_wrbuf", 32'(wr_buf), 1);
        pixels(PXLS, 90);
        drive(0, 0, 0, 0);
        chk("s1_last_addr", 32'(wr_addr), 4799);
        vs_edge();
        chk("s1_writes", m_nwr - w0, 9600);
        chk("s1_cnt", 32'(frame_cnt), 2);
        chk("s1_done", 32'(done), 1);
        chk("s1_wrbuf", 32'(wr_buf), 0);
        chk("s1_rdbuf", 32'(rd_buf), 1);
        chk("s1_ndone", m_ndone - d0, 2);
        mode = 2'b11;
        vs_edge();
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("s1_idle", 32'(busy), 0);

        // Single-shot: only the first frame is written.
        mode = 2'b01;
        do_reset();
        drive(0, 0, 0, 0);
        chk("s2_wait_start", 32'(busy), 0);
        w0 = m_nwr; d0 = m_ndone;
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        chk("s2_armed", 32'(busy), 1);
        vs_edge();
        pixels(50, 70);
        vs_edge();
        pixels(50, 70);
        vs_edge();
        pixels(50, 70);
        drive(0, 0, 0, 0);
        chk("s2_writes", m_nwr - w0, 50);
        chk("s2_ndone", m_ndone - d0, 1);
        chk("s2_busy", 32'(busy), 0);
        chk("s2_cnt", 32'(frame_cnt), 1);

        // Burst of three, with a stray start mid-capture, then burst_len 0.
        mode = 2'b10; burst_len = 8'd3;
        do_reset();
        d0 = m_ndone;
        drive(0, 0, 0, 1);
        vs_edge();
        for (int f = 0; f < 3; f++) begin
            pixels($urandom_range(1, 40), 80);
            if (f == 0) drive(0, 0, 0, 1);
            vs_edge();
        end
        pixels(20, 80);
        vs_edge();
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("s3_ndone", m_ndone - d0, 3);
        chk("s3_busy", 32'(busy), 0);
        chk("s3_cnt", 32'(frame_cnt), 3);
        burst_len = 8'd0;
        d0 = m_ndone;
        drive(0, 0, 0, 1);
        vs_edge();
        pixels(10, 80);
        vs_edge();
        pixels(10, 80);
        vs_edge();
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("s3_len0_ndone", m_ndone - d0, 1);
        chk("s3_len0_cnt", 32'(frame_cnt), 4);
        chk("s3_len0_bufs", 32'({wr_buf, rd_buf}), 32'b01);

        // Overflow: 4805 pixels in one frame.
        mode = 2'b01;
        do_reset();
        w0 = m_nwr;
        drive(0, 0, 0, 1);
        vs_edge();
        pixels(PXLS + 5, 95);
        drive(0, 0, 0, 0);
        chk("s4_ovf", 32'(overflow), 1);
        chk("s4_writes", m_nwr - w0, 4800);
        chk("s4_last_addr", 32'(wr_addr), 4799);
        vs_edge();
        repeat (5) drive(0, 0, 0, 0);
        chk("s4_ovf_sticky", 32'(overflow), 1);
        chk("s4_busy", 32'(busy), 0);
        do_reset();
        chk("s4_ovf_cleared", 32'(overflow), 0);

        // Freeze requested mid-frame, then reset mid-frame on the next run.
        mode = 2'b00;
        do_reset();
        w0 = m_nwr;
        vs_edge();
        pixels(2000, 90);
        mode = 2'b11;
        pixels(PXLS - 2000, 90);
        drive(0, 0, 0, 0);
        chk("s5_still_busy", 32'(busy), 1);
        chk("s5_writes", m_nwr - w0, 4800);
        vs_edge();
        chk("s5_done", 32'(done), 1);
        chk("s5_cnt", 32'(frame_cnt), 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("s5_idle", 32'(busy), 0);
        mode = 2'b00;
        drive(0, 0, 0, 0);
        vs_edge();
        pixels(100, 100);
        drive(1, 0, 1, 0);
        w0 = m_nwr;
        drive(0, 0, 1, 0);
        chk("s5_rst_wr_en", 32'(wr_en), 0);
        chk("s5_rst_cnt", 32'(frame_cnt), 0);
        pixels(20, 100);
        drive(0, 0, 0, 0);
        chk("s5_no_writes_after_rst", m_nwr - w0, 0);

        // Frame counter wrap 255 -> 0.
        mode = 2'b00;
        do_reset();
        vs_edge();
        for (int f = 0; f < 255; f++) begin
            pixels(2, 100);
            vs_edge();
        end
        chk("s6_cnt255", 32'(frame_cnt), 255);
`ifdef FRAME_GRAY_EN
        chk("s6_gray255", 32'(frame_gray), 32'h80);
`else
        chk("s6_gray255", 32'(frame_gray), 0);
`endif
        pixels(2, 100);
        vs_edge();
        chk("s6_cnt_wrap", 32'(frame_cnt), 0);
        chk("s6_gray_wrap", 32'(frame_gray), 0);
        mode = 2'b11;
        vs_edge();
        drive(0, 0, 0, 0);

        // Randomized traffic across all modes with occasional resets.
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) burst_len = 8'($urandom_range(0, 4));
            drive(($urandom_range(0, 2999) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 99) < 60),
                  ($urandom_range(0, 49) == 0));
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
